// File: rtl/imm_gen_pkg.sv
// Shared types, opcode constants and the combinational immediate decoder
// for the RISC-V decode-stage immediate generator.
package imm_gen_pkg;

    localparam logic [6:0] OPC_LOAD       = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM     = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC      = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32  = 7'b0011011;
    localparam logic [6:0] OPC_STORE      = 7'b0100011;
    localparam logic [6:0] OPC_OP         = 7'b0110011;
    localparam logic [6:0] OPC_LUI        = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH     = 7'b1100011;
    localparam logic [6:0] OPC_JALR       = 7'b1100111;
    localparam logic [6:0] OPC_JAL        = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM     = 7'b1110011;

    typedef enum logic [2:0] {
        FMT_R   = 3'd0,
        FMT_I   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_U   = 3'd4,
        FMT_J   = 3'd5,
        FMT_SH  = 3'd6,
        FMT_ILL = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        SB_EMPTY = 2'd0,
        SB_MAIN  = 2'd1,
        SB_FULL  = 2'd2
    } sb_state_e;

    typedef struct packed {
        fmt_e        fmt;
        logic        illegal;
        logic [63:0] imm;
    } imm_dec_t;

    // Immediates are built at 64 bits; narrower datapaths keep the low bits,
    // which are still a correct sign/zero extension.
    function automatic imm_dec_t imm_decode(input logic [31:0] instr, input int xlen);
        imm_dec_t    r;
        logic [2:0]  f3;
        logic        is_shift;
        logic [63:0] i_imm;
        f3       = instr[14:12];
        is_shift = (f3 == 3'b001) || (f3 == 3'b101);
        i_imm    = {{52{instr[31]}}, instr[31:20]};
        r.fmt     = FMT_ILL;
        r.illegal = 1'b1;
        r.imm     = '0;
        case (instr[6:0])
            OPC_OP_IMM: begin
                if (!is_shift) begin
                    r.fmt = FMT_I; r.illegal = 1'b0; r.imm = i_imm;
                end else if (xlen == 64) begin
                    r.fmt = FMT_SH; r.illegal = 1'b0; r.imm = {58'b0, instr[25:20]};
                end else if (!instr[25]) begin
                    r.fmt = FMT_SH; r.illegal = 1'b0; r.imm = {59'b0, instr[24:20]};
                end
            end
            OPC_OP_IMM_32: begin
                // Word shifts only ever take a 5-bit shamt, so instr[25] is reserved.
                if (xlen == 64 && !is_shift) begin
                    r.fmt = FMT_I; r.illegal = 1'b0; r.imm = i_imm;
                end else if (xlen == 64 && !instr[25]) begin
                    r.fmt = FMT_SH; r.illegal = 1'b0; r.imm = {59'b0, instr[24:20]};
                end
            end
            OPC_LOAD, OPC_JALR, OPC_SYSTEM: begin
                r.fmt = FMT_I; r.illegal = 1'b0; r.imm = i_imm;
            end
            OPC_STORE: begin
                r.fmt = FMT_S; r.illegal = 1'b0;
                r.imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                r.fmt = FMT_B; r.illegal = 1'b0;
                r.imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                r.fmt = FMT_U; r.illegal = 1'b0;
                r.imm = {{32{instr[31]}}, instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                r.fmt = FMT_J; r.illegal = 1'b0;
                r.imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_OP: begin
                r.fmt = FMT_R; r.illegal = 1'b0;
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Upstream instruction handshake and downstream immediate handshake of imm_gen_pipe.
interface imm_gen_pipe_if
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    fmt_e             out_fmt;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_instr, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );

    modport slave (
        input  in_valid, in_instr, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_tag
    );
endinterface

// File: rtl/imm_skid_buf.sv
// Two-entry valid/ready buffer (main + skid) whose in_ready comes straight from a flop.
//  state    | meaning
//  SB_EMPTY | nothing held, out_valid low
//  SB_MAIN  | main entry presented downstream, skid free
//  SB_FULL  | main presented, skid holds the next entry, upstream stalled
module imm_skid_buf
    import imm_gen_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);
    sb_state_e    state, state_nxt;
    logic         in_ready_q;
    logic [W-1:0] main_q, skid_q;
    logic         acc, drain;
    logic         load_main, load_skid, main_from_skid;

    assign acc       = in_valid && in_ready_q;
    assign drain     = (state != SB_EMPTY) && out_ready;
    assign in_ready  = in_ready_q;
    assign out_valid = (state != SB_EMPTY);
    assign out_data  = main_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SB_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state      <= state_nxt;
            in_ready_q <= (state_nxt != SB_FULL);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            SB_EMPTY: if (acc) state_nxt = SB_MAIN;
            SB_MAIN: begin
                if (acc && !drain)      state_nxt = SB_FULL;
                else if (!acc && drain) state_nxt = SB_EMPTY;
            end
            SB_FULL:  if (drain) state_nxt = SB_MAIN;
            default:  state_nxt = SB_EMPTY;
        endcase
    end

    always_comb begin
        load_main      = acc && ((state == SB_EMPTY) || (state == SB_MAIN && drain));
        load_skid      = acc && (state == SB_MAIN) && !drain;
        main_from_skid = (state == SB_FULL) && drain;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (main_from_skid)  main_q <= skid_q;
            else if (load_main)  main_q <= in_data;
            if (load_skid)       skid_q <= in_data;
        end
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator: combinational decode, registered through a
// 2-entry skid buffer, plus a saturating count of illegal instructions handed off.
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    imm_gen_pipe_if.slave    bus,
    output logic [CNT_W-1:0] err_cnt
);
    localparam int PW = 3 + 1 + XLEN + TAG_W;

    imm_dec_t      dec;
    logic [PW-1:0] in_pl, out_pl;
    logic          dec_unused;

    always_comb dec = imm_decode(bus.in_instr, XLEN);

    assign dec_unused = ^dec.imm;
    assign in_pl = {dec.fmt, dec.illegal, dec.imm[XLEN-1:0], bus.in_tag};

    imm_skid_buf #(.W(PW)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (in_pl),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (out_pl)
    );

    assign bus.out_tag     = out_pl[TAG_W-1:0];
    assign bus.out_imm     = out_pl[TAG_W+XLEN-1:TAG_W];
    assign bus.out_illegal = out_pl[TAG_W+XLEN];
    assign bus.out_fmt     = fmt_e'(out_pl[PW-1:PW-3]);

    always_ff @(posedge clk) begin
        if (rst)
            err_cnt <= '0;
        else if (bus.out_valid && bus.out_ready && bus.out_illegal && (err_cnt != '1))
            err_cnt <= err_cnt + 1'b1;
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: 32- and 64-bit instances share one stimulus stream.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] err32, err64;
    int         errors = 0;
    int         checks = 0;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) if32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) if64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(8)) dut32 (
        .clk(clk), .rst(rst), .bus(if32.slave), .err_cnt(err32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(8)) dut64 (
        .clk(clk), .rst(rst), .bus(if64.slave), .err_cnt(err64));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%0h exp=%0h", name, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [4:0] tg, input logic ordy);
        if32.in_valid = v; if32.in_instr = ins; if32.in_tag = tg; if32.out_ready = ordy;
        if64.in_valid = v; if64.in_instr = ins; if64.in_tag = tg; if64.out_ready = ordy;
    endtask

    initial begin
        drive(1'b0, 32'h0, 5'd0, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", if32.out_valid, 0);
        check("rst_in_ready", if32.in_ready, 1);
        check("rst_err_cnt", err32, 0);
        check("rst_imm", if32.out_imm, 0);
        check("rst_fmt", if32.out_fmt, 0);
        check("rst_illegal", if32.out_illegal, 0);
        check("rst_tag", if32.out_tag, 0);
        check("rst64_in_ready", if64.in_ready, 1);

        rst = 1'b0;
        drive(1'b1, 32'hFFF00093, 5'd1, 1'b1);
        @(negedge clk);
        check("addi_valid", if32.out_valid, 1);
        check("addi_imm", if32.out_imm, 64'hFFFFFFFF);
        check("addi_fmt", if32.out_fmt, 1);
        check("addi_illegal", if32.out_illegal, 0);
        check("addi_tag", if32.out_tag, 1);
        check("addi64_imm", if64.out_imm, 64'hFFFFFFFFFFFFFFFF);

        drive(1'b1, 32'hFE112E23, 5'd2, 1'b1);
        @(negedge clk);
        check("sw_imm", if32.out_imm, 64'hFFFFFFFC);
        check("sw_fmt", if32.out_fmt, 2);
        check("sw_tag", if32.out_tag, 2);

        drive(1'b1, 32'hFE000CE3, 5'd3, 1'b1);
        @(negedge clk);
        check("beq_imm", if32.out_imm, 64'hFFFFFFF8);
        check("beq_fmt", if32.out_fmt, 3);

        drive(1'b1, 32'h123450B7, 5'd4, 1'b1);
        @(negedge clk);
        check("lui_imm", if32.out_imm, 64'h12345000);
        check("lui_fmt", if32.out_fmt, 4);
        check("lui64_imm", if64.out_imm, 64'h0000000012345000);

        drive(1'b1, 32'h800000B7, 5'd5, 1'b1);
        @(negedge clk);
        check("luineg64_imm", if64.out_imm, 64'hFFFFFFFF80000000);

        drive(1'b1, 32'h0010006F, 5'd6, 1'b1);
        @(negedge clk);
        check("jal_imm", if32.out_imm, 64'h800);
        check("jal_fmt", if32.out_fmt, 5);

        drive(1'b1, 32'h02009093, 5'd7, 1'b1);
        @(negedge clk);
        check("slli32_illegal", if32.out_illegal, 1);
        check("slli32_imm", if32.out_imm, 0);
        check("slli32_fmt", if32.out_fmt, 7);
        check("slli64_fmt", if64.out_fmt, 6);
        check("slli64_imm", if64.out_imm, 32);
        check("slli64_illegal", if64.out_illegal, 0);
        check("slli_err_before", err32, 0);

        drive(1'b1, 32'h002081B3, 5'd8, 1'b1);
        @(negedge clk);
        check("add_fmt", if32.out_fmt, 0);
        check("add_imm", if32.out_imm, 0);
        check("slli_err32", err32, 1);
        check("slli_err64", err64, 0);

        drive(1'b1, 32'hFFF0809B, 5'd9, 1'b1);
        @(negedge clk);
        check("addiw32_fmt", if32.out_fmt, 7);
        check("addiw32_illegal", if32.out_illegal, 1);
        check("addiw64_fmt", if64.out_fmt, 1);
        check("addiw64_imm", if64.out_imm, 64'hFFFFFFFFFFFFFFFF);

        drive(1'b0, 32'h0, 5'd0, 1'b1);
        @(negedge clk);
        check("idle_valid", if32.out_valid, 0);
        check("addiw_err32", err32, 2);
        check("addiw_err64", err64, 0);

        // Backpressure: A held, B in skid, C stalled.
        drive(1'b1, 32'h00500093, 5'd10, 1'b0);
        @(negedge clk);
        check("bp_a_valid", if32.out_valid, 1);
        check("bp_a_imm", if32.out_imm, 5);
        check("bp_ready1", if32.in_ready, 1);
        drive(1'b1, 32'h12345037, 5'd11, 1'b0);
        @(negedge clk);
        check("bp_a_hold_tag", if32.out_tag, 10);
        check("bp_ready_fall", if32.in_ready, 0);
        drive(1'b1, 32'h0000006F, 5'd12, 1'b0);
        @(negedge clk);
        check("bp_a_hold2_imm", if32.out_imm, 5);
        check("bp_a_hold2_tag", if32.out_tag, 10);
        check("bp_ready_low", if32.in_ready, 0);
        drive(1'b1, 32'h0000006F, 5'd12, 1'b1);
        @(negedge clk);
        check("bp_b_tag", if32.out_tag, 11);
        check("bp_b_imm", if32.out_imm, 64'h12345000);
        check("bp_ready_rise", if32.in_ready, 1);
        @(negedge clk);
        check("bp_c_tag", if32.out_tag, 12);
        check("bp_c_fmt", if32.out_fmt, 5);
        check("bp_c_valid", if32.out_valid, 1);
        drive(1'b0, 32'h0, 5'd0, 1'b1);
        @(negedge clk);
        check("bp_drained", if32.out_valid, 0);

        // Saturation of the illegal counter.
        drive(1'b1, 32'h0000007F, 5'd1, 1'b1);
        @(negedge clk);
        check("ill_fmt", if32.out_fmt, 7);
        check("ill_imm", if32.out_imm, 0);
        check("ill_flag", if32.out_illegal, 1);
        for (int i = 1; i < 300; i++) @(negedge clk);
        drive(1'b0, 32'h0, 5'd0, 1'b1);
        @(negedge clk);
        check("sat_err32", err32, 255);
        check("sat_err64", err64, 255);

        drive(1'b1, 32'h00100093, 5'd1, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h00200093, 5'd2, 1'b0);
        @(negedge clk);
        check("full_in_ready", if32.in_ready, 0);
        check("full_valid", if32.out_valid, 1);
        rst = 1'b1;
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        @(negedge clk);
        check("rst2_out_valid", if32.out_valid, 0);
        check("rst2_in_ready", if32.in_ready, 1);
        check("rst2_err_cnt", err32, 0);
        check("rst2_imm", if32.out_imm, 0);
        check("rst2_tag", if32.out_tag, 0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b1);
        @(negedge clk);
        check("rst2_no_ghost", if32.out_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
